// File: rtl/gpu_pkg.sv
// Shared types and helpers for the kernel launch engine.
package gpu_pkg;

  // Per-core slot lifecycle: waiting for work, running a block, one-cycle core reset.
  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_BUSY    = 2'd1,
    SLOT_RECYCLE = 2'd2
  } slot_state_t;

  // Kernel-level sequencing.
  typedef enum logic [1:0] {
    DISP_IDLE = 2'd0,
    DISP_RUN  = 2'd1,
    DISP_DONE = 2'd2
  } dispatcher_state_t;

  // Integer ceiling division; den is a nonzero elaboration constant at every call site.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/block_dispatcher_core_slot.sv
// One dispatch slot: tracks a single core through start, done and a one-cycle reset,
// and holds the block id / thread count presented to that core.
module core_slot
  import gpu_pkg::*;
#(
  parameter int ID_BITS  = 8,
  parameter int TPB_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,          // active-low, synchronous
  input  logic                dispatch_i,
  input  logic [ID_BITS-1:0]  block_id_i,
  input  logic [TPB_BITS-1:0] thread_count_i,
  input  logic                core_done_i,
  output logic                free_o,
  output logic                retire_o,
  output logic                core_start_o,
  output logic                core_reset_o,
  output logic [ID_BITS-1:0]  block_id_o,
  output logic [TPB_BITS-1:0] thread_count_o
);

  slot_state_t         state_q;
  logic                start_q;
  logic                core_reset_q;
  logic [ID_BITS-1:0]  block_id_q;
  logic [TPB_BITS-1:0] thread_count_q;

  // Slot FSM with registered core controls; core_done only matters while BUSY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= SLOT_FREE;
      start_q        <= 1'b0;
      core_reset_q   <= 1'b1;
      block_id_q     <= '0;
      thread_count_q <= '0;
    end else begin
      case (state_q)
        SLOT_FREE: begin
          core_reset_q <= 1'b0;
          if (dispatch_i) begin
            state_q        <= SLOT_BUSY;
            start_q        <= 1'b1;
            block_id_q     <= block_id_i;
            thread_count_q <= thread_count_i;
          end
        end
        SLOT_BUSY: begin
          if (core_done_i) begin
            state_q      <= SLOT_RECYCLE;
            start_q      <= 1'b0;
            core_reset_q <= 1'b1;
          end
        end
        SLOT_RECYCLE: begin
          state_q      <= SLOT_FREE;
          core_reset_q <= 1'b0;
        end
        default: begin
          state_q      <= SLOT_FREE;
          start_q      <= 1'b0;
          core_reset_q <= 1'b0;
        end
      endcase
    end
  end

  // Retire is combinational so the top counts it on the same edge the slot leaves BUSY.
  assign free_o         = (state_q == SLOT_FREE);
  assign retire_o       = (state_q == SLOT_BUSY) && core_done_i;
  assign core_start_o   = start_q;
  assign core_reset_o   = core_reset_q;
  assign block_id_o     = block_id_q;
  assign thread_count_o = thread_count_q;

endmodule

// File: rtl/block_dispatcher.sv
// Kernel launch engine: holds the thread-count register, splits the kernel into
// blocks and hands them out one per edge to the lowest-index free core.
module block_dispatcher
  import gpu_pkg::*;
#(
  parameter int NUM_CORES         = 4,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 8,
  parameter int TPB_BITS          = $clog2(THREADS_PER_BLOCK + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset,   // active-low, synchronous
  input  logic                                   start,
  output logic                                   done,
  input  logic                                   device_control_write_enable,
  input  logic [THREAD_COUNT_BITS-1:0]           device_control_data,
  output logic [NUM_CORES-1:0]                   core_start,
  output logic [NUM_CORES-1:0]                   core_reset,
  output logic [NUM_CORES*THREAD_COUNT_BITS-1:0] core_block_id,
  output logic [NUM_CORES*TPB_BITS-1:0]          core_thread_count,
  input  logic [NUM_CORES-1:0]                   core_done
);

  localparam int W = THREAD_COUNT_BITS;

  dispatcher_state_t state_q;
  logic [W-1:0]      thread_count_q;
  logic [W-1:0]      next_block_q;
  logic [W-1:0]      blocks_retired_q;
  logic              done_q;

  logic [W:0]          total_blocks;
  logic                blocks_left;
  logic                last_block;
  logic [TPB_BITS-1:0] dispatch_count;
  logic [NUM_CORES-1:0] slot_free;
  logic [NUM_CORES-1:0] slot_retire;
  logic [NUM_CORES-1:0] dispatch_vec;
  logic                 dispatch_any;
  logic [W-1:0]         retire_cnt;
  logic [W:0]           blocks_retired_d;
  logic [W-1:0]         next_block_d;

  // Block arithmetic; total_blocks carries an extra bit so the round-up never wraps.
  always_comb begin
    total_blocks = (W + 1)'(ceil_div(32'(thread_count_q), 32'(THREADS_PER_BLOCK)));
    blocks_left  = ({1'b0, next_block_q} < total_blocks);
    last_block   = ({1'b0, next_block_q} == (total_blocks - 1'b1));
    // The remainder always fits TPB_BITS, so modular arithmetic at that width is exact.
    if (last_block)
      dispatch_count = TPB_BITS'(thread_count_q)
                     - TPB_BITS'(total_blocks - 1'b1) * TPB_BITS'(THREADS_PER_BLOCK);
    else
      dispatch_count = TPB_BITS'(THREADS_PER_BLOCK);
  end

  // Priority picker: one block per edge, lowest-index free slot wins.
  always_comb begin
    dispatch_vec = '0;
    dispatch_any = 1'b0;
    if (state_q == DISP_RUN && blocks_left) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (slot_free[i] && !dispatch_any) begin
          dispatch_vec[i] = 1'b1;
          dispatch_any    = 1'b1;
        end
      end
    end
  end

  // Popcount of same-edge retirements and the resulting counters.
  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++)
      retire_cnt = retire_cnt + {{(W-1){1'b0}}, slot_retire[i]};
    blocks_retired_d = {1'b0, blocks_retired_q} + {1'b0, retire_cnt};
    next_block_d     = dispatch_any ? (next_block_q + 1'b1) : next_block_q;
  end

  // Kernel FSM: launch, run until every block has retired, hold done until the next launch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= DISP_IDLE;
      thread_count_q   <= '0;
      next_block_q     <= '0;
      blocks_retired_q <= '0;
      done_q           <= 1'b0;
    end else begin
      case (state_q)
        DISP_IDLE: begin
          if (device_control_write_enable)
            thread_count_q <= device_control_data;
          if (start) begin
            next_block_q     <= '0;
            blocks_retired_q <= '0;
            if (thread_count_q == '0) begin
              state_q <= DISP_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DISP_RUN;
              done_q  <= 1'b0;
            end
          end
        end
        DISP_RUN: begin
          next_block_q     <= next_block_d;
          blocks_retired_q <= blocks_retired_d[W-1:0];
          if (blocks_retired_d == total_blocks) begin
            state_q <= DISP_DONE;
            done_q  <= 1'b1;
          end
        end
        DISP_DONE: begin
          if (device_control_write_enable)
            thread_count_q <= device_control_data;
          if (!start)
            state_q <= DISP_IDLE;
        end
        default: state_q <= DISP_IDLE;
      endcase
    end
  end

  assign done = done_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_slot
      core_slot #(
        .ID_BITS  (W),
        .TPB_BITS (TPB_BITS)
      ) u_slot (
        .clk            (clk),
        .reset          (reset),
        .dispatch_i     (dispatch_vec[gi]),
        .block_id_i     (next_block_q),
        .thread_count_i (dispatch_count),
        .core_done_i    (core_done[gi]),
        .free_o         (slot_free[gi]),
        .retire_o       (slot_retire[gi]),
        .core_start_o   (core_start[gi]),
        .core_reset_o   (core_reset[gi]),
        .block_id_o     (core_block_id[gi*W +: W]),
        .thread_count_o (core_thread_count[gi*TPB_BITS +: TPB_BITS])
      );
    end
  endgenerate

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher: directed scenarios plus randomized runs,
// compared every cycle against a kernel-level reference model.
module tb_block_dispatcher;

  localparam int NC  = 4;
  localparam int TPB = 4;
  localparam int W   = 8;
  localparam int TB  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            done;
  logic            we = 1'b0;
  logic [W-1:0]    data = '0;
  logic [NC-1:0]   core_start;
  logic [NC-1:0]   core_reset;
  logic [NC*W-1:0] core_block_id;
  logic [NC*TB-1:0] core_thread_count;
  logic [NC-1:0]   core_done = '0;

  int tests = 0;
  int fails = 0;

  block_dispatcher #(
    .NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .THREAD_COUNT_BITS(W), .TPB_BITS(TB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .device_control_write_enable(we), .device_control_data(data),
    .core_start(core_start), .core_reset(core_reset),
    .core_block_id(core_block_id), .core_thread_count(core_thread_count),
    .core_done(core_done)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 running, 2 finished; slot stage 0 free, 1 busy, 2 recycling.
  int m_phase = 0, m_tc = 0, m_next = 0, m_ret = 0;
  bit m_done = 0;
  int m_stage[NC];
  bit m_rst[NC];
  int m_id[NC];
  int m_cnt[NC];

  function automatic void model_step();
    int total, nret, new_tc;
    bit was_free[NC];
    if (!reset) begin
      m_phase = 0; m_tc = 0; m_next = 0; m_ret = 0; m_done = 0;
      for (int i = 0; i < NC; i++) begin
        m_stage[i] = 0; m_rst[i] = 1; m_id[i] = 0; m_cnt[i] = 0;
      end
      return;
    end
    total = (m_tc + TPB - 1) / TPB;
    nret = 0;
    for (int i = 0; i < NC; i++) begin
      was_free[i] = (m_stage[i] == 0);
      if (m_stage[i] == 1 && core_done[i]) begin m_stage[i] = 2; nret++; end
      else if (m_stage[i] == 2) m_stage[i] = 0;
      m_rst[i] = (m_stage[i] == 2);
    end
    case (m_phase)
      0: begin
        new_tc = we ? int'(data) : m_tc;
        if (start) begin
          m_next = 0; m_ret = 0;
          if (m_tc == 0) begin m_phase = 2; m_done = 1; end
          else begin m_phase = 1; m_done = 0; end
        end
        m_tc = new_tc;
      end
      1: begin
        if (m_next < total) begin
          for (int i = 0; i < NC; i++) begin
            if (was_free[i]) begin
              m_stage[i] = 1;
              m_id[i] = m_next;
              m_cnt[i] = (m_next == total - 1) ? m_tc - (total - 1) * TPB : TPB;
              m_next++;
              break;
            end
          end
        end
        m_ret += nret;
        if (m_ret == total) begin m_phase = 2; m_done = 1; end
      end
      default: begin
        if (we) m_tc = int'(data);
        if (!start) m_phase = 0;
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare_all();
    logic [NC-1:0] es, er;
    logic [NC*W-1:0] eid;
    logic [NC*TB-1:0] ecnt;
    for (int i = 0; i < NC; i++) begin
      es[i] = (m_stage[i] == 1);
      er[i] = m_rst[i];
      eid[i*W +: W] = W'(m_id[i]);
      ecnt[i*TB +: TB] = TB'(m_cnt[i]);
    end
    check("done", 64'(done), 64'(m_done));
    check("core_start", 64'(core_start), 64'(es));
    check("core_reset", 64'(core_reset), 64'(er));
    check("core_block_id", 64'(core_block_id), 64'(eid));
    check("core_thread_count", 64'(core_thread_count), 64'(ecnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; we = 1'b0; core_done = '0;
    tick();
    check("reset_core_reset_lit", 64'(core_reset), 64'hF);
    check("reset_done_lit", 64'(done), 64'h0);
    tick();
    reset = 1'b1;
  endtask

  task automatic write_tc(input int v);
    we = 1'b1; data = W'(v);
    tick();
    we = 1'b0;
  endtask

  // Random core_done (and occasional ignored writes) until the kernel completes, bounded.
  task automatic run_to_done(input int bound);
    int n = 0;
    while (m_phase != 2 && n < bound) begin
      core_done = NC'($urandom_range(0, 15));
      if (m_phase == 1 && $urandom_range(0, 7) == 0) begin
        we = 1'b1; data = W'($urandom_range(0, 255));
      end
      tick();
      we = 1'b0;
      n++;
    end
    core_done = '0;
    tests++;
    if (m_phase != 2) begin
      fails++;
      $display("FAIL run_timeout: got phase %0d expected 2 after %0d cycles", m_phase, n);
    end
  endtask

  initial begin
    // thread_count=10: three blocks on cores 0..2, counts 4,4,2
    do_reset();
    write_tc(10);
    start = 1'b1;
    tick();
    check("t10_no_start_at_accept", 64'(core_start), 64'h0);
    tick();
    check("t10_start0", 64'(core_start), 64'h1);
    tick();
    check("t10_start1", 64'(core_start), 64'h3);
    tick();
    check("t10_start2", 64'(core_start), 64'h7);
    check("t10_id2", 64'(core_block_id[2*W +: W]), 64'd2);
    check("t10_cnt0", 64'(core_thread_count[0 +: TB]), 64'd4);
    check("t10_cnt2", 64'(core_thread_count[2*TB +: TB]), 64'd2);
    tick();
    check("t10_core3_idle", 64'(core_start), 64'h7);
    core_done = 4'b0111;
    tick();
    check("t10_done", 64'(done), 64'h1);
    core_done = '0; start = 1'b0;
    tick();

    // thread_count=0: done at the start edge, no core started
    do_reset();
    write_tc(0);
    start = 1'b1;
    tick();
    check("t0_done", 64'(done), 64'h1);
    check("t0_no_start", 64'(core_start), 64'h0);
    tick();
    start = 1'b0;
    tick();

    // thread_count=24: recycle core 1, then blocks 4 and 5 go to freed cores
    do_reset();
    write_tc(24);
    start = 1'b1;
    repeat (5) tick();
    check("t24_all_started", 64'(core_start), 64'hF);
    core_done = 4'b0010;
    tick();
    check("t24_rst1_on", 64'(core_reset), 64'h2);
    core_done = '0;
    tick();
    check("t24_rst1_off", 64'(core_reset), 64'h0);
    tick();
    check("t24_core1_id4", 64'(core_block_id[1*W +: W]), 64'd4);
    core_done = 4'b0001;
    tick();
    core_done = '0;
    tick();
    tick();
    check("t24_core0_id5", 64'(core_block_id[0 +: W]), 64'd5);
    check("t24_not_done", 64'(done), 64'h0);
    core_done = 4'hF;
    tick();
    check("t24_done", 64'(done), 64'h1);
    core_done = '0; start = 1'b0;
    tick();

    // Write during RUN is ignored; write in DONE takes effect for the next run
    do_reset();
    write_tc(10);
    start = 1'b1;
    tick();
    we = 1'b1; data = 8'd40;
    tick();
    we = 1'b0;
    tick(); tick();
    core_done = 4'b0111;
    tick();
    core_done = '0;
    check("wr_old_done", 64'(done), 64'h1);
    check("wr_old_cnt2", 64'(core_thread_count[2*TB +: TB]), 64'd2);
    we = 1'b1; data = 8'd40;
    tick();
    we = 1'b0; start = 1'b0;
    tick();
    start = 1'b1;
    repeat (5) tick();
    check("wr_new_all_started", 64'(core_start), 64'hF);
    check("wr_new_counts", 64'(core_thread_count), 64'h924);
    run_to_done(1000);
    start = 1'b0;
    tick();

    // Simultaneous retirements: 4 blocks, two pairs
    do_reset();
    write_tc(16);
    start = 1'b1;
    repeat (5) tick();
    core_done = 4'b0011;
    tick();
    check("pair_not_early", 64'(done), 64'h0);
    core_done = 4'b1100;
    tick();
    check("pair_done", 64'(done), 64'h1);
    core_done = '0; start = 1'b0;
    tick();

    // Mid-run reset abandons the run; a new run then completes
    do_reset();
    write_tc(40);
    start = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    check("mid_rst_core_reset", 64'(core_reset), 64'hF);
    check("mid_rst_core_start", 64'(core_start), 64'h0);
    check("mid_rst_done", 64'(done), 64'h0);
    reset = 1'b1;
    write_tc(13);
    run_to_done(1000);
    start = 1'b0;
    tick();

    // Randomized kernels
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 4) == 0) do_reset();
      write_tc($urandom_range(0, 63));
      tick();
      start = 1'b1;
      run_to_done(1500);
      start = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
